// File: rtl/fsm_arbiter_rr.sv
// N-channel request/grant arbiter with run-time fixed or round-robin priority,
// back-to-back hand-over and a hold limit that preempts the owner when others wait.
module fsm_arbiter_rr #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rr_mode,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               busy,
  output logic               preempt
);

  // state | meaning
  // IDLE  | no owner, gnt = 0
  // GRANT | gnt_id owns the resource, gnt = 1 << gnt_id

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0]      HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [NUM_REQ-1:0] GNT_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IDW-1:0] last_owner;
  logic [HW-1:0]  hold_cnt;

  logic [NUM_REQ-1:0] others;
  logic [IDW-1:0]     load_idx;
  logic               load;
  logic               load_pre;
  logic               go_idle;

  function automatic logic [IDW-1:0] select_idx(input logic [NUM_REQ-1:0] v,
                                                input logic rr,
                                                input logic [IDW-1:0] last);
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    win = '0;
    // Scan from lowest to highest priority so the last hit is the winner.
    for (int j = NUM_REQ; j >= 1; j--) begin
      if (rr) idx = IDW'((int'(last) + j) % NUM_REQ);
      else    idx = IDW'(j - 1);
      if (v[idx]) win = idx;
    end
    return win;
  endfunction

  // gnt is zero in IDLE, so this is simply req there; in GRANT it masks the owner.
  assign others   = req & ~gnt;
  assign load_idx = select_idx(others, rr_mode, last_owner);

  always_comb begin
    load     = 1'b0;
    load_pre = 1'b0;
    go_idle  = 1'b0;
    case (state)
      IDLE: load = |req;
      GRANT: begin
        if (!req[gnt_id]) begin
          if (|others) load = 1'b1;
          else         go_idle = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && (|others)) begin
          load     = 1'b1;
          load_pre = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_id     <= '0;
      busy       <= 1'b0;
      preempt    <= 1'b0;
      last_owner <= IDW'(NUM_REQ - 1);
      hold_cnt   <= '0;
    end else if (load) begin
      state      <= GRANT;
      gnt        <= GNT_ONE << load_idx;
      gnt_id     <= load_idx;
      busy       <= 1'b1;
      preempt    <= load_pre;
      last_owner <= load_idx;
      hold_cnt   <= HW'(1);
    end else if (go_idle) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      preempt <= 1'b0;
    end else begin
      preempt <= 1'b0;
      if ((state == GRANT) && (MAX_HOLD != 0) && (hold_cnt != HOLD_MAX))
        hold_cnt <= hold_cnt + HW'(1);
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(gnt) && (!busy || (gnt == (GNT_ONE << gnt_id))) && (busy == (|gnt)));
`endif

endmodule

// File: tb/tb_fsm_arbiter_rr.sv
// Scoreboard bench for fsm_arbiter_rr: two instances (hold limit 4 and unlimited)
// share stimulus; a behavioural model predicts every cycle, plus directed checks.
module tb_fsm_arbiter_rr;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic       rr_mode;

  logic [3:0] gnt_h4, gnt_h0;
  logic [1:0] id_h4, id_h0;
  logic       busy_h4, busy_h0, pre_h4, pre_h0;

  int n_vec = 0;
  int n_mis = 0;

  logic [7:0] q_h4[$];
  logic [7:0] q_h0[$];

  int m_own[2];
  int m_hold[2];
  int m_last[2];
  bit m_pre[2];
  int maxh[2] = '{4, 0};

  fsm_arbiter_rr #(.NUM_REQ(4), .MAX_HOLD(4)) u_h4 (
    .clock(clock), .reset(reset), .req(req), .rr_mode(rr_mode),
    .gnt(gnt_h4), .gnt_id(id_h4), .busy(busy_h4), .preempt(pre_h4));

  fsm_arbiter_rr #(.NUM_REQ(4), .MAX_HOLD(0)) u_h0 (
    .clock(clock), .reset(reset), .req(req), .rr_mode(rr_mode),
    .gnt(gnt_h0), .gnt_id(id_h0), .busy(busy_h0), .preempt(pre_h0));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input bit rr, input int last);
    if (!rr) begin
      for (int i = 0; i < 4; i++) if (v[i]) return i;
    end else begin
      for (int s = 1; s <= 4; s++) if (v[(last + s) % 4]) return (last + s) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d] = -1; m_hold[d] = 0; m_last[d] = 3; m_pre[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] r, input bit rr);
    int w;
    logic [3:0] rest;
    m_pre[d] = 1'b0;
    if (m_own[d] < 0) begin
      if (r != 0) begin
        w = pick(r, rr, m_last[d]);
        m_own[d] = w; m_hold[d] = 1; m_last[d] = w;
      end
    end else begin
      rest = r & ~(4'b0001 << m_own[d]);
      if (!r[m_own[d]]) begin
        if (r != 0) begin
          w = pick(r, rr, m_last[d]);
          m_own[d] = w; m_hold[d] = 1; m_last[d] = w;
        end else m_own[d] = -1;
      end else if (maxh[d] != 0 && m_hold[d] == maxh[d] && rest != 0) begin
        w = pick(rest, rr, m_last[d]);
        m_own[d] = w; m_hold[d] = 1; m_last[d] = w; m_pre[d] = 1'b1;
      end else if (maxh[d] != 0 && m_hold[d] < maxh[d]) begin
        m_hold[d]++;
      end
    end
  endtask

  function automatic logic [7:0] model_out(input int d);
    logic [3:0] g;
    if (m_own[d] < 0) return 8'h00;
    g = 4'b0001 << m_own[d];
    return {g, 2'(m_own[d]), 1'b1, m_pre[d]};
  endfunction

  task automatic tick();
    @(posedge clock);
    if (!reset) model_reset();
    else for (int d = 0; d < 2; d++) model_step(d, req, rr_mode);
    q_h4.push_back(model_out(0));
    q_h0.push_back(model_out(1));
    #1;
    check_eq("sb_h4", {gnt_h4, id_h4, busy_h4, pre_h4}, q_h4.pop_front());
    check_eq("sb_h0", {gnt_h0, id_h0, busy_h0, pre_h0}, q_h0.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    req = 4'b0000;
    tick(); tick();
    reset = 1'b1;
  endtask

  logic [4:0] t5_exp[10];
  int         t3_exp[5];

  initial begin
    reset = 1'b0; req = 4'b0000; rr_mode = 1'b0;
    model_reset();
    #1;
    check_eq("rst_h4", {gnt_h4, id_h4, busy_h4, pre_h4}, 8'h00);
    check_eq("rst_h0", {gnt_h0, id_h0, busy_h0, pre_h0}, 8'h00);
    tick();
    reset = 1'b1;

    // 1: single requester, fixed priority
    rr_mode = 1'b0; req = 4'b0001;
    tick();
    check_eq("t1_first", {gnt_h4, id_h4, busy_h4, pre_h4}, 8'b0001_00_1_0);
    repeat (4) tick();
    req = 4'b0000;
    tick();
    check_eq("t1_drop", {gnt_h4, busy_h4}, 5'b0000_0);

    // 2: all requesting, fixed priority; unlimited instance never moves
    do_reset();
    rr_mode = 1'b0; req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("t2_h0", {gnt_h0, pre_h0}, 5'b0001_0);
    end

    // 3: round-robin, each agent drops its request the cycle it is granted
    do_reset();
    rr_mode = 1'b1; req = 4'b1111;
    t3_exp = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t3_order", {id_h4, busy_h4, id_h0, busy_h0},
               {2'(t3_exp[i]), 1'b1, 2'(t3_exp[i]), 1'b1});
      req = 4'b1111 & ~(4'b0001 << t3_exp[i]);
    end

    // 4: direct hand-over without an idle bubble
    do_reset();
    rr_mode = 1'b0; req = 4'b0001;
    tick();
    req = 4'b0101;
    tick();
    req = 4'b0100;
    tick();
    check_eq("t4_handover", {gnt_h4, busy_h4, gnt_h0, busy_h0}, 10'b0100_1_0100_1);

    // 5: hold limit 4, two round-robin requesters
    do_reset();
    rr_mode = 1'b1; req = 4'b0011;
    t5_exp = '{5'b0001_0, 5'b0001_0, 5'b0001_0, 5'b0001_0,
               5'b0010_1, 5'b0010_0, 5'b0010_0, 5'b0010_0,
               5'b0001_1, 5'b0001_0};
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t5_preempt", {gnt_h4, pre_h4}, t5_exp[i]);
    end

    // 6: asynchronous reset mid-grant, then round-robin restarts its scan
    req = 4'b0001; rr_mode = 1'b1;
    tick(); tick();
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("t6_async_h4", {gnt_h4, id_h4, busy_h4, pre_h4}, 8'h00);
    check_eq("t6_async_h0", {gnt_h0, id_h0, busy_h0, pre_h0}, 8'h00);
    tick();
    reset = 1'b1;
    req = 4'b1000;
    tick();
    check_eq("t6_restart", {gnt_h4, id_h4, gnt_h0, id_h0}, 12'b1000_11_1000_11);
    req = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
